// File: rtl/ac97_pkg.sv
// Shared AC'97 command-sequencer types: register map, FSM states, and the
// packing of the master/headphone volume word.
package ac97_pkg;

  localparam int VOL_W = 5;

  localparam logic [7:0] AC97_REG_MASTER = 8'h02;
  localparam logic [7:0] AC97_REG_HP     = 8'h04;
  localparam logic [7:0] AC97_REG_PCM    = 8'h18;

  typedef enum logic [1:0] {WAIT_READY, INIT, RUN} state_t;

  // Left attenuation in 12:8, right in 4:0, mute in bit 15.
  function automatic logic [15:0] vol_word(input logic mute, input logic [VOL_W-1:0] lvl);
    return {mute, 2'b00, lvl, 3'b000, lvl};
  endfunction

endpackage

// File: rtl/ac97_cmd_sequencer_if.sv
// Slot 1/2 command bus between the sequencer (master) and the frame serializer.
interface ac97_cmd_sequencer_if;
  logic        cmd_valid;
  logic [7:0]  cmd_addr;
  logic [15:0] cmd_data;

  modport master (output cmd_valid, cmd_addr, cmd_data);
  modport slave  (input  cmd_valid, cmd_addr, cmd_data);
endinterface

// File: rtl/ac97_vol_ctrl.sv
// Saturating attenuation counter; 'changed' flags a request that actually
// moves the level (saturated or conflicting requests are dropped).
module ac97_vol_ctrl
  import ac97_pkg::*;
#(
  parameter logic [VOL_W-1:0] VOL_INIT = 5'd8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             up,
  input  logic             down,
  output logic [VOL_W-1:0] level,
  output logic             changed
);

  logic dec, inc;

  always_comb begin
    dec     = up && !down && (level != '0);
    inc     = down && !up && (level != '1);
    changed = dec || inc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   level <= VOL_INIT;
    else if (dec) level <= level - 1'b1;
    else if (inc) level <= level + 1'b1;
  end

endmodule

// File: rtl/ac97_cmd_sequencer.sv
// AC'97 control-slot scheduler: waits for codec ready, writes the init table
// one entry per frame, then forwards volume changes. Optional: AC97_MUTE_EN.
module ac97_cmd_sequencer
  import ac97_pkg::*;
#(
  parameter logic [VOL_W-1:0] VOL_INIT     = 5'd8,
  parameter int               READY_FRAMES = 4,
  parameter logic [15:0]      PCM_VOL      = 16'h0808
) (
  input  logic                     bit_clk,
  input  logic                     reset_n,
  input  logic                     frame_sync,
  input  logic                     codec_ready,
  input  logic                     vol_up,
  input  logic                     vol_down,
`ifdef AC97_MUTE_EN
  input  logic                     mute_toggle,
`endif
  ac97_cmd_sequencer_if.master     cmd,
  output logic [VOL_W-1:0]         vol_level,
  output logic                     init_done,
  output logic                     busy
);

  state_t      state, state_n;
  logic [3:0]  cnt, cnt_n;
  logic [1:0]  idx, idx_n;
  logic        pending, pending_n;
  logic        done_n, busy_n;
  logic        valid_q, valid_n;
  logic [7:0]  addr_q, addr_n;
  logic [15:0] data_q, data_n;
  logic        vol_chg, mute, tgl;
  logic [15:0] vw;

  ac97_vol_ctrl #(.VOL_INIT(VOL_INIT)) u_vol (
    .clk    (bit_clk),
    .rst_n  (reset_n),
    .up     (vol_up),
    .down   (vol_down),
    .level  (vol_level),
    .changed(vol_chg)
  );

`ifdef AC97_MUTE_EN
  // Mute survives codec loss; only reset clears it.
  always_ff @(posedge bit_clk or negedge reset_n) begin
    if (!reset_n) mute <= 1'b0;
    else          mute <= mute ^ mute_toggle;
  end
  assign tgl = mute_toggle;
`else
  assign mute = 1'b0;
  assign tgl  = 1'b0;
`endif

  assign vw = vol_word(mute, vol_level);

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    idx_n     = idx;
    pending_n = pending;
    done_n    = init_done;
    valid_n   = valid_q;
    addr_n    = addr_q;
    data_n    = data_q;
    if (frame_sync) begin
      if (state != WAIT_READY && !codec_ready) begin
        state_n   = WAIT_READY;
        cnt_n     = '0;
        pending_n = 1'b0;
        done_n    = 1'b0;
        valid_n   = 1'b0;
      end else begin
        unique case (state)
          WAIT_READY: begin
            valid_n = 1'b0;
            if (codec_ready) begin
              cnt_n = (cnt == 4'hF) ? cnt : cnt + 4'd1;
              if (cnt_n >= 4'(READY_FRAMES)) begin
                state_n = INIT;
                idx_n   = '0;
              end
            end else begin
              cnt_n = '0;
            end
          end
          INIT: begin
            idx_n   = idx + 2'd1;
            valid_n = 1'b1;
            unique case (idx)
              2'd0: begin addr_n = AC97_REG_MASTER; data_n = vw;      end
              2'd1: begin addr_n = AC97_REG_HP;     data_n = vw;      end
              2'd2: begin addr_n = AC97_REG_PCM;    data_n = PCM_VOL; end
              default: begin
                valid_n = 1'b0;
                done_n  = 1'b1;
                state_n = RUN;
              end
            endcase
          end
          RUN: begin
            valid_n = pending;
            if (pending) begin
              addr_n    = AC97_REG_MASTER;
              data_n    = vw;
              pending_n = 1'b0;
            end
          end
          default: state_n = WAIT_READY;
        endcase
      end
    end
    // A change on the issuing edge re-arms for the following frame.
    if (state == RUN && state_n == RUN && (vol_chg || tgl)) pending_n = 1'b1;
    busy_n = (state_n != RUN) || pending_n || valid_n;
  end

  always_ff @(posedge bit_clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= WAIT_READY;
      cnt       <= '0;
      idx       <= '0;
      pending   <= 1'b0;
      init_done <= 1'b0;
      busy      <= 1'b0;
      valid_q   <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      idx       <= idx_n;
      pending   <= pending_n;
      init_done <= done_n;
      busy      <= busy_n;
      valid_q   <= valid_n;
      addr_q    <= addr_n;
      data_q    <= data_n;
    end
  end

  assign cmd.cmd_valid = valid_q;
  assign cmd.cmd_addr  = addr_q;
  assign cmd.cmd_data  = data_q;

endmodule

// File: doc/ac97_cmd_sequencer.md
Name: ac97_cmd_sequencer

Overview:
Control-slot scheduler for the AC'97 frame serializer. Waits for codec ready, then issues the init register-write table one write per frame. After init it turns user volume up/down requests into master-volume writes. It drives the cmd_addr/cmd_data/cmd_valid inputs that the serializer packs into slots 1 and 2; the serializer supplies the frame boundary pulse.

Parameters:
VOL_INIT, 5'd8, master/headphone attenuation after reset (0 = loudest, 31 = quietest)
READY_FRAMES, 4, consecutive frames codec_ready must be sampled high before init starts (1..15)
PCM_VOL, 16'h0808, data word written to the PCM Out Volume register

Ports:
bit_clk  input  1  AC'97 bit clock; the only clock
reset_n  input  1  asynchronous active-low reset
frame_sync  input  1  one-cycle pulse in the last bit of each 256-bit frame (serializer count==255)
codec_ready  input  1  codec-ready bit from the incoming slot 0 tag; valid when frame_sync=1
vol_up  input  1  one-cycle request: attenuation -1
vol_down  input  1  one-cycle request: attenuation +1
cmd_valid  output  1  slot 1/2 carry a valid write this frame (drives tag bits 1–2)
cmd_addr  output  8  register address; bit 7 = 0 (write)
cmd_data  output  16  register write data
vol_level  output  5  current attenuation
init_done  output  1  init table complete
busy  output  1  high in WAIT_READY and INIT, or while a volume write is pending/issuing

Behaviour:
- Reset (async, any state): state=WAIT_READY, cmd_valid=0, cmd_addr=0, cmd_data=0, vol_level=VOL_INIT, init_done=0, busy=0, ready counter=0, pending=0. busy goes to 1 on the first clock after release.
- cmd_* outputs change only on a bit_clk edge where frame_sync=1, so they stay stable for the whole next frame.
- Volume word VW = {1'b0, 2'b00, vol_level, 3'b000, vol_level}: left in bits 12:8, right in bits 4:0.
- WAIT_READY:
  - At each frame_sync, codec_ready=1 increments the ready counter (saturating); 0 clears it.
  - When the counter reaches READY_FRAMES, go to INIT with index 0 at that same edge.
  - cmd_valid=0 throughout.
- INIT: at each frame_sync, present table[index] with cmd_valid=1, then index+1.
  - Table: 0 -> (8'h02, VW); 1 -> (8'h04, VW); 2 -> (8'h18, PCM_VOL).
  - On the frame_sync after entry 2 is presented: cmd_valid=0, init_done=1, go to RUN. The table therefore takes exactly 3 frames.
- RUN:
  - vol_up with vol_level>0: vol_level-1 on the next clock. vol_up at 0: no change.
  - vol_down with vol_level<31: vol_level+1. vol_down at 31: no change.
  - vol_up and vol_down in the same cycle: ignored.
  - Any accepted change sets pending. Several changes before the next frame_sync coalesce into one write with the latest VW.
  - At frame_sync with pending=1: present (8'h02, VW), cmd_valid=1, clear pending. A change on that same cycle re-sets pending for the following frame.
  - At frame_sync with pending=0: cmd_valid=0.
- Volume requests in WAIT_READY/INIT still update vol_level but do not set pending; the init table uses the current VW.
- Codec loss: codec_ready=0 at any frame_sync in INIT or RUN -> WAIT_READY, init_done=0, cmd_valid=0, pending=0, counter=0. The full table is reissued after re-ready.
- Worst-case latency from a vol pulse to cmd_valid: 257 clocks.

Optional Feature:
AC97_MUTE_EN:
- Defined: adds input mute_toggle (1-bit pulse). Each pulse flips a mute flag (reset 0) and sets pending in RUN. VW bit 15 = mute flag. Mute is preserved through codec-loss re-init.
- Undefined: no port; VW bit 15 is always 0.

Decomposition:
- Shared package ac97_pkg:
  - register address constants AC97_REG_MASTER=8'h02, AC97_REG_HP=8'h04, AC97_REG_PCM=8'h18
  - state encoding {WAIT_READY, INIT, RUN}
  - VOL_W=5
  - the VW packing function
- One sub-module, ac97_vol_ctrl: saturating up/down attenuation counter with change strobe, shared by the front panel.

Test Plan:
- Reset release, codec_ready=1 from frame 0 -> after READY_FRAMES=4 frame_syncs the next 3 frames carry (02,0808),(04,0808),(18,0808) with cmd_valid=1; then cmd_valid=0 and init_done=1.
- codec_ready pattern 1,1,0,1,1,1,1 -> init starts only after the final run of 4 highs.
- RUN with vol_level=8: three vol_up pulses in one frame -> one write (02,0505); 9 further vol_up -> vol_level stops at 0, last write 0000.
- vol_level=31, vol_down -> no change, no write; vol_up+vol_down in the same cycle -> no change, cmd_valid stays 0.
- codec_ready=0 mid-RUN -> init_done=0 on that frame_sync; after 4 ready frames the 3-entry table is reissued with the current vol_level.
- Assert reset_n low mid-INIT, off a clock edge -> all outputs go to reset values immediately; with AC97_MUTE_EN, mute_toggle at vol 8 -> write (02,8808).
